toy_itcm_ack_buf: RTL
=====================

Name: toy_itcm_ack_buf

Overview:
Credit-gated request pass-through and response buffer between the fetch unit and the ITCM model. The ITCM accepts every request and returns its ack a fixed time later, and it cannot be stalled on the ack side. This block therefore holds back fetch requests unless a buffer slot is reserved for the eventual ack. Acks are queued in order and presented to fetch with a full valid/ready handshake, so fetch backpressure never loses data.

Parameters:
ADDR_WIDTH, 32, fetch address width
DATA_WIDTH, 128, ack data width
ID_WIDTH, 12, entry id width (opcode+mshr index+rob id), carried opaquely
DEPTH, 4, ack FIFO entries and max reserved credits; power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
up_req_vld  in  1  fetch request valid
up_req_rdy  out  1  fetch request ready
up_req_addr  in  ADDR_WIDTH  fetch address
up_req_id  in  ID_WIDTH  fetch entry id
mem_req_vld  out  1  request to ITCM
mem_req_rdy  in  1  ITCM ready (ITCM ties to 1)
mem_req_addr  out  ADDR_WIDTH  address to ITCM
mem_req_id  out  ID_WIDTH  entry id to ITCM
mem_ack_vld  in  1  ITCM ack valid; no ready, must be absorbed
mem_ack_data  in  DATA_WIDTH  ITCM ack data
mem_ack_id  in  ID_WIDTH  ITCM ack entry id
up_ack_vld  out  1  ack to fetch valid
up_ack_rdy  in  1  fetch ack ready
up_ack_data  out  DATA_WIDTH  ack data to fetch
up_ack_id  out  ID_WIDTH  ack entry id to fetch
credit_used  out  $clog2(DEPTH+1)  reserved slots (in-flight + queued)
err_overflow  out  1  sticky: ack arrived with FIFO full
err_unexp_ack  out  1  sticky: ack arrived with zero in-flight

Behaviour:
- Reset (async, rst_n low): credit_used=0, inflight=0, FIFO empty (wr/rd ptr=0), up_ack_vld=0, err_*=0. up_req_rdy=0 is forced only while rst_n=0; the FIFO data RAM is not reset. A reset mid-operation drops all in-flight and queued acks. Any ack arriving after reset deassertion with inflight=0 sets err_unexp_ack.
- Request path (combinational):
  - mem_req_vld = up_req_vld & (credit_used<DEPTH).
  - up_req_rdy = mem_req_rdy & (credit_used<DEPTH).
  - addr and id pass straight through.
  - issue = mem_req_vld & mem_req_rdy.
- Counters (registered, next edge):
  - pop = up_ack_vld & up_ack_rdy.
  - credit_used += issue - pop. Simultaneous issue and pop leave it unchanged.
  - inflight += issue - accept, where accept = mem_ack_vld & (inflight!=0 or issue in the same cycle is excluded; i.e. inflight is checked pre-update).
  - Invariant: credit_used = inflight + fifo_count <= DEPTH.
- Ack path:
  - On mem_ack_vld with inflight!=0 and FIFO not full: write {id,data} at wr_ptr, wr_ptr+1 mod DEPTH.
  - Full/empty are distinguished with an extra pointer wrap bit.
  - up_ack_vld = FIFO not empty. Head is driven from rd_ptr. On pop, rd_ptr+1 mod DEPTH.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Ordering: strict FIFO. The ITCM returns acks in request order, so ids exit in issue order.
- Latency: mem_ack to up_ack_vld is 1 cycle (registered FIFO), unless the bypass feature below is enabled.
- Boundaries:
  - credit_used==DEPTH: up_req_rdy=0 regardless of mem_req_rdy.
  - mem_ack_vld with FIFO full (only reachable under a protocol violation): drop the ack, set err_overflow.
  - mem_ack_vld with inflight==0: drop the ack, set err_unexp_ack, counters unchanged.
  - up_ack_rdy held low: head data and id stay stable while up_ack_vld=1.
  - Both err flags clear only on reset.

Optional Feature:
Macro TOY_ITCM_ACK_BYPASS_EN.
- Defined: when the FIFO is empty and mem_ack_vld is accepted, up_ack_vld is asserted in the same cycle with mem_ack_data and mem_ack_id.
  - If up_ack_rdy=1, the ack is consumed and not written; credit and inflight both decrement in that cycle.
  - If up_ack_rdy=0, the ack is written to the FIFO as normal.
- Undefined: no combinational path from mem_ack to up_ack; minimum latency is 1 cycle.

Test Plan:
- Single fetch: DEPTH=4, addr=0x100, id=0x005, ITCM 1-cycle, up_ack_rdy=1 -> up_ack_vld 1 cycle after mem_ack (0 with bypass), id=0x005, credit_used returns 0.
- Credit stall: up_ack_rdy=0, 6 back-to-back requests -> exactly 4 issued, up_req_rdy=0 from 5th, credit_used=4. Then release rdy -> acks exit ids in order and 2 more requests issue.
- Simultaneous push/pop: continuous requests with up_ack_rdy=1 -> credit_used steady at 1 (2 without bypass), no bubbles, 100 ids returned in order.
- Backpressure hold: up_ack_rdy toggles 0/1 every cycle -> head data and id stable while rdy=0, no loss or duplication across 50 transactions.
- Unexpected ack: inject mem_ack_vld with inflight=0 -> err_unexp_ack=1 next cycle, up_ack_vld stays 0, credit_used=0.
- Reset mid-flight: 3 requests outstanding, pulse rst_n low -> all outputs at reset values asynchronously. A stale ack after release sets err_unexp_ack.

Source files
------------

// File: rtl/toy_itcm_ack_buf_if.sv
// rtl/toy_itcm_ack_buf_if.sv - fetch/ITCM request and ack handshake bundle
// slave is the buffer's view; master is the fetch/ITCM side.
interface toy_itcm_ack_buf_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 12
);
  logic                  up_req_vld;
  logic                  up_req_rdy;
  logic [ADDR_WIDTH-1:0] up_req_addr;
  logic [ID_WIDTH-1:0]   up_req_id;

  logic                  mem_req_vld;
  logic                  mem_req_rdy;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [ID_WIDTH-1:0]   mem_req_id;

  logic                  mem_ack_vld;
  logic [DATA_WIDTH-1:0] mem_ack_data;
  logic [ID_WIDTH-1:0]   mem_ack_id;

  logic                  up_ack_vld;
  logic                  up_ack_rdy;
  logic [DATA_WIDTH-1:0] up_ack_data;
  logic [ID_WIDTH-1:0]   up_ack_id;

  modport slave (
    input  up_req_vld, up_req_addr, up_req_id,
    output up_req_rdy,
    output mem_req_vld, mem_req_addr, mem_req_id,
    input  mem_req_rdy,
    input  mem_ack_vld, mem_ack_data, mem_ack_id,
    output up_ack_vld, up_ack_data, up_ack_id,
    input  up_ack_rdy
  );

  modport master (
    output up_req_vld, up_req_addr, up_req_id,
    input  up_req_rdy,
    input  mem_req_vld, mem_req_addr, mem_req_id,
    output mem_req_rdy,
    output mem_ack_vld, mem_ack_data, mem_ack_id,
    input  up_ack_vld, up_ack_data, up_ack_id,
    output up_ack_rdy
  );
endinterface

// File: rtl/toy_itcm_ack_buf.sv
// rtl/toy_itcm_ack_buf.sv - credit-gated ITCM request pass-through with in-order ack FIFO
// Define TOY_ITCM_ACK_BYPASS_EN for a same-cycle ack path when the FIFO is empty.
module toy_itcm_ack_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 12,
  parameter int DEPTH      = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  toy_itcm_ack_buf_if.slave    bus,
  output logic [CW-1:0]        credit_used,
  output logic                 err_overflow,
  output logic                 err_unexp_ack
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ID_WIDTH + DATA_WIDTH;

  logic [CW-1:0]         inflight;
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [EW-1:0]         ram [DEPTH];
  logic [EW-1:0]         head;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  has_credit;
  logic                  issue;
  logic                  empty;
  logic                  full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  fifo_pop;

  // A request may only leave when a slot is guaranteed for its ack.
  assign has_credit       = credit_used < CW'(DEPTH);
  assign req_addr         = bus.up_req_addr;
  assign bus.mem_req_vld  = bus.up_req_vld & has_credit;
  assign bus.up_req_rdy   = rst_n & bus.mem_req_rdy & has_credit;
  assign bus.mem_req_addr = req_addr;
  assign bus.mem_req_id   = bus.up_req_id;
  assign issue            = bus.mem_req_vld & bus.mem_req_rdy;

  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign accept   = bus.mem_ack_vld & (inflight != '0) & ~full;
  assign fifo_pop = ~empty & bus.up_ack_rdy;

`ifdef TOY_ITCM_ACK_BYPASS_EN
  logic bypass_vld;
  assign bypass_vld     = empty & accept;
  assign bus.up_ack_vld = ~empty | bypass_vld;
  assign head           = empty ? {bus.mem_ack_id, bus.mem_ack_data} : ram[rd_ptr[PW-1:0]];
  assign push           = accept & ~(bypass_vld & bus.up_ack_rdy);
`else
  assign bus.up_ack_vld = ~empty;
  assign head           = ram[rd_ptr[PW-1:0]];
  assign push           = accept;
`endif

  assign bus.up_ack_id   = head[EW-1:DATA_WIDTH];
  assign bus.up_ack_data = head[DATA_WIDTH-1:0];
  assign pop             = bus.up_ack_vld & bus.up_ack_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_used   <= '0;
      inflight      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_overflow  <= 1'b0;
      err_unexp_ack <= 1'b0;
    end else begin
      credit_used <= credit_used + CW'(issue) - CW'(pop);
      inflight    <= inflight + CW'(issue) - CW'(accept);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.mem_ack_vld && full) begin
        err_overflow <= 1'b1;
      end
      if (bus.mem_ack_vld && (inflight == '0)) begin
        err_unexp_ack <= 1'b1;
      end
    end
  end

  // Data storage is deliberately left out of reset; the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      ram[wr_ptr[PW-1:0]] <= {bus.mem_ack_id, bus.mem_ack_data};
    end
  end
endmodule
